// File: rtl/btb_set_assoc.sv
// Set-associative branch target buffer: 1-cycle lookup, update port with
// 2-bit direction counters and true-LRU allocation, plus a one-set-per-cycle flush engine.
module btb_set_assoc #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SETS   = 16,
  parameter int WAYS       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  pred_valid,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  update_valid,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic [ADDR_WIDTH-1:0] update_target,
  input  logic                  update_taken,
  input  logic                  update_is_branch,
  input  logic                  flush_req,
  output logic                  flush_busy
);
  localparam int INDEX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2;
  localparam int AGE_W      = $clog2(WAYS);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                                           state_q, state_d;
  logic [INDEX_BITS-1:0]                            cnt_q, cnt_d;
  logic [NUM_SETS-1:0][WAYS-1:0]                    valid_q, valid_d;
  logic [NUM_SETS-1:0][WAYS-1:0][TAG_BITS-1:0]      tag_q, tag_d;
  logic [NUM_SETS-1:0][WAYS-1:0][ADDR_WIDTH-1:0]    target_q, target_d;
  logic [NUM_SETS-1:0][WAYS-1:0][1:0]               ctr_q, ctr_d;
  logic [NUM_SETS-1:0][WAYS-1:0][AGE_W-1:0]         age_q, age_d;
  logic                                             pred_valid_q, pred_valid_d;
  logic                                             pred_hit_q, pred_hit_d;
  logic                                             pred_taken_q, pred_taken_d;
  logic [ADDR_WIDTH-1:0]                            pred_target_q, pred_target_d;

  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0]   lk_tag, up_tag;
  logic                  lk_hit, up_hit, inv_found, do_touch;
  logic [AGE_W-1:0]      lk_way, up_way, inv_way, lru_way, touch_way, alloc_way;
  logic                  unused_lsbs;

  assign lk_idx = lookup_pc[INDEX_BITS+1:2];
  assign lk_tag = lookup_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign up_idx = update_pc[INDEX_BITS+1:2];
  assign up_tag = update_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign unused_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

  // Way search for both ports; reads only current-state contents.
  always_comb begin
    lk_hit    = 1'b0;
    lk_way    = '0;
    up_hit    = 1'b0;
    up_way    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = AGE_W'(w);
      end
      if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
        up_hit = 1'b1;
        up_way = AGE_W'(w);
      end
      if (age_q[up_idx][w] == AGE_W'(WAYS-1)) lru_way = AGE_W'(w);
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!valid_q[up_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = AGE_W'(w);
      end
    end
    alloc_way = inv_found ? inv_way : lru_way;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    target_d  = target_q;
    ctr_d     = ctr_q;
    age_d     = age_q;
    do_touch  = 1'b0;
    touch_way = up_way;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (update_valid && update_is_branch) begin
          if (up_hit) begin
            target_d[up_idx][up_way] = update_target;
            if (update_taken && ctr_q[up_idx][up_way] != 2'b11)
              ctr_d[up_idx][up_way] = ctr_q[up_idx][up_way] + 2'b01;
            else if (!update_taken && ctr_q[up_idx][up_way] != 2'b00)
              ctr_d[up_idx][up_way] = ctr_q[up_idx][up_way] - 2'b01;
            do_touch = 1'b1;
          end else if (update_taken) begin
            valid_d[up_idx][alloc_way]  = 1'b1;
            tag_d[up_idx][alloc_way]    = up_tag;
            target_d[up_idx][alloc_way] = update_target;
            ctr_d[up_idx][alloc_way]    = 2'b10;
            touch_way                   = alloc_way;
            do_touch                    = 1'b1;
          end
        end
      end
      FLUSH: begin
        for (int w = 0; w < WAYS; w++) begin
          valid_d[cnt_q][w] = 1'b0;
          age_d[cnt_q][w]   = AGE_W'(w);
        end
        if (cnt_q == INDEX_BITS'(NUM_SETS-1)) state_d = IDLE;
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Touched way becomes MRU; younger ways age by one, older ones keep their age.
    if (do_touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == touch_way) age_d[up_idx][w] = '0;
        else if (age_q[up_idx][w] < age_q[up_idx][touch_way])
          age_d[up_idx][w] = age_q[up_idx][w] + 1'b1;
      end
    end
  end

  always_comb begin
    pred_valid_d  = lookup_valid && (state_d != FLUSH);
    pred_hit_d    = lookup_valid && lk_hit;
    pred_taken_d  = lookup_valid && lk_hit && ctr_q[lk_idx][lk_way][1];
    pred_target_d = (lookup_valid && lk_hit) ? target_q[lk_idx][lk_way] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      valid_q       <= '0;
      tag_q         <= '0;
      target_q      <= '0;
      ctr_q         <= '0;
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= AGE_W'(w);
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      ctr_q         <= ctr_d;
      age_q         <= age_d;
      pred_valid_q  <= pred_valid_d;
      pred_hit_q    <= pred_hit_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_hit    = pred_hit_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign flush_busy  = (state_q == FLUSH);
endmodule

// File: tb/tb_btb_set_assoc.sv
// Bench for btb_set_assoc: recency-list table model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_btb_set_assoc;
  localparam int NS = 16;
  localparam int W  = 4;
  localparam int IB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        pred_valid, pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        update_valid = 1'b0;
  logic [31:0] update_pc = '0;
  logic [31:0] update_target = '0;
  logic        update_taken = 1'b0;
  logic        update_is_branch = 1'b0;
  logic        flush_req = 1'b0;
  logic        flush_busy;

  int n_cmp = 0;
  int n_bad = 0;

  btb_set_assoc dut (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target),
    .update_valid(update_valid), .update_pc(update_pc), .update_target(update_target),
    .update_taken(update_taken), .update_is_branch(update_is_branch),
    .flush_req(flush_req), .flush_busy(flush_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: table contents plus a per-set recency list (front = MRU).
  bit          mv[NS][W];
  int unsigned mtag[NS][W];
  logic [31:0] mtgt[NS][W];
  int          mctr[NS][W];
  int          order[NS][$];
  bit          mflush;
  int          mcnt;
  logic        e_pv, e_hit, e_tk, e_busy;
  logic [31:0] e_tgt;

  function automatic void m_reset_set(int s);
    order[s].delete();
    for (int w = 0; w < W; w++) order[s].push_back(w);
  endfunction

  function automatic void m_touch(int s, int w);
    for (int k = 0; k < order[s].size(); k++)
      if (order[s][k] == w) begin
        order[s].delete(k);
        break;
      end
    order[s].push_front(w);
  endfunction

  always @(posedge clk or posedge reset) begin
    int li, ui, lw, uw, victim;
    int unsigned lt, ut;
    bit lh, uh, nh;
    if (reset) begin
      for (int s = 0; s < NS; s++) begin
        for (int w = 0; w < W; w++) begin
          mv[s][w] = 0; mtag[s][w] = 0; mtgt[s][w] = '0; mctr[s][w] = 0;
        end
        m_reset_set(s);
      end
      mflush = 0; mcnt = 0;
      e_pv = 0; e_hit = 0; e_tk = 0; e_tgt = '0; e_busy = 0;
    end else begin
      li = int'((lookup_pc >> 2) % NS);
      lt = lookup_pc >> (IB + 2);
      lh = 0; lw = 0;
      for (int w = 0; w < W; w++)
        if (mv[li][w] && mtag[li][w] == lt) begin lh = 1; lw = w; end
      nh = lookup_valid && lh;
      e_hit = nh;
      e_tk  = nh && (mctr[li][lw] >= 2);
      e_tgt = nh ? mtgt[li][lw] : 32'h0;
      if (mflush) begin
        for (int w = 0; w < W; w++) mv[mcnt][w] = 0;
        m_reset_set(mcnt);
        mcnt++;
        if (mcnt == NS) mflush = 0;
      end else if (flush_req) begin
        mflush = 1; mcnt = 0;
      end else if (update_valid && update_is_branch) begin
        ui = int'((update_pc >> 2) % NS);
        ut = update_pc >> (IB + 2);
        uh = 0; uw = 0;
        for (int w = 0; w < W; w++)
          if (mv[ui][w] && mtag[ui][w] == ut) begin uh = 1; uw = w; end
        if (uh) begin
          mtgt[ui][uw] = update_target;
          if (update_taken) mctr[ui][uw] = (mctr[ui][uw] == 3) ? 3 : mctr[ui][uw] + 1;
          else              mctr[ui][uw] = (mctr[ui][uw] == 0) ? 0 : mctr[ui][uw] - 1;
          m_touch(ui, uw);
        end else if (update_taken) begin
          victim = -1;
          for (int w = 0; w < W; w++)
            if (!mv[ui][w] && victim < 0) victim = w;
          if (victim < 0) victim = order[ui][W-1];
          mv[ui][victim] = 1; mtag[ui][victim] = ut;
          mtgt[ui][victim] = update_target; mctr[ui][victim] = 2;
          m_touch(ui, victim);
        end
      end
      e_pv   = lookup_valid && !mflush;
      e_busy = mflush;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("mdl_pred_valid", {31'b0, pred_valid}, {31'b0, e_pv});
      check("mdl_flush_busy", {31'b0, flush_busy}, {31'b0, e_busy});
      if (e_pv) begin
        check("mdl_pred_hit", {31'b0, pred_hit}, {31'b0, e_hit});
        check("mdl_pred_taken", {31'b0, pred_taken}, {31'b0, e_tk});
        check("mdl_pred_target", pred_target, e_tgt);
      end
    end
  end

  task automatic look(input logic [31:0] pc);
    lookup_valid = 1'b1; lookup_pc = pc;
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    update_valid = 1'b1; update_is_branch = 1'b1;
    update_pc = pc; update_target = tgt; update_taken = tk;
    @(posedge clk); #1;
    update_valid = 1'b0; update_is_branch = 1'b0;
  endtask

  task automatic expect_pred(input string nm, input logic hit, input logic tk, input logic [31:0] tgt);
    check({nm, "_valid"}, {31'b0, pred_valid}, 32'd1);
    check({nm, "_hit"}, {31'b0, pred_hit}, {31'b0, hit});
    check({nm, "_taken"}, {31'b0, pred_taken}, {31'b0, tk});
    check({nm, "_target"}, pred_target, tgt);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // T1: empty table misses
    look(32'h100);
    expect_pred("t1", 1'b0, 1'b0, 32'h0);

    // T2: allocate, then walk the counter down, up to saturation and back
    upd(32'h100, 32'h200, 1'b1);
    look(32'h100);
    expect_pred("t2_alloc", 1'b1, 1'b1, 32'h200);
    upd(32'h100, 32'h200, 1'b0);
    upd(32'h100, 32'h200, 1'b0);
    look(32'h100);
    expect_pred("t2_nt", 1'b1, 1'b0, 32'h200);
    repeat (4) upd(32'h100, 32'h200, 1'b1);
    look(32'h100);
    expect_pred("t2_sat", 1'b1, 1'b1, 32'h200);
    upd(32'h100, 32'h200, 1'b0);
    look(32'h100);
    expect_pred("t2_sat_dec1", 1'b1, 1'b1, 32'h200);
    upd(32'h100, 32'h200, 1'b0);
    look(32'h100);
    expect_pred("t2_sat_dec2", 1'b1, 1'b0, 32'h200);

    // T3: fill set 0, refresh 0x000, allocate 0x100 -> LRU 0x040 evicted
    pulse_reset();
    upd(32'h000, 32'h1000, 1'b1);
    upd(32'h040, 32'h1040, 1'b1);
    upd(32'h080, 32'h1080, 1'b1);
    upd(32'h0C0, 32'h10C0, 1'b1);
    upd(32'h000, 32'h2000, 1'b1);
    upd(32'h100, 32'h1100, 1'b1);
    look(32'h040);
    expect_pred("t3_evicted", 1'b0, 1'b0, 32'h0);
    look(32'h000);
    expect_pred("t3_000", 1'b1, 1'b1, 32'h2000);
    look(32'h080);
    expect_pred("t3_080", 1'b1, 1'b1, 32'h1080);
    look(32'h0C0);
    expect_pred("t3_0c0", 1'b1, 1'b1, 32'h10C0);
    look(32'h100);
    expect_pred("t3_100", 1'b1, 1'b1, 32'h1100);

    // T4: same-cycle lookup and allocate of 0x300 reads the old contents
    lookup_valid = 1'b1; lookup_pc = 32'h300;
    update_valid = 1'b1; update_is_branch = 1'b1;
    update_pc = 32'h300; update_target = 32'h777; update_taken = 1'b1;
    @(posedge clk); #1;
    lookup_valid = 1'b0; update_valid = 1'b0; update_is_branch = 1'b0;
    @(negedge clk);
    expect_pred("t4_same", 1'b0, 1'b0, 32'h0);
    look(32'h300);
    expect_pred("t4_next", 1'b1, 1'b1, 32'h777);

    // T5: flush with continuous lookups and an update dropped mid-flush
    upd(32'h404, 32'h4404, 1'b1);
    upd(32'h408, 32'h4408, 1'b1);
    look(32'h404);
    expect_pred("t5_pre", 1'b1, 1'b1, 32'h4404);
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    lookup_valid = 1'b1; lookup_pc = 32'h404;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (flush_busy) begin
        busy_cnt++;
        check("t5_pv_in_flush", {31'b0, pred_valid}, 32'd0);
      end
      if (i == 3) begin
        update_valid = 1'b1; update_is_branch = 1'b1;
        update_pc = 32'h500; update_target = 32'h5500; update_taken = 1'b1;
      end
      if (i == 4) begin
        update_valid = 1'b0; update_is_branch = 1'b0;
      end
    end
    lookup_valid = 1'b0;
    check("t5_busy_cycles", busy_cnt, 32'd16);
    look(32'h404);
    expect_pred("t5_404", 1'b0, 1'b0, 32'h0);
    look(32'h408);
    expect_pred("t5_408", 1'b0, 1'b0, 32'h0);
    look(32'h500);
    expect_pred("t5_500_dropped", 1'b0, 1'b0, 32'h0);
    look(32'h000);
    expect_pred("t5_000", 1'b0, 1'b0, 32'h0);

    // T6: reset five cycles into a flush
    upd(32'h600, 32'h6600, 1'b1);
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("t6_busy_reset", {31'b0, flush_busy}, 32'd0);
    check("t6_pv_reset", {31'b0, pred_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    look(32'h600);
    expect_pred("t6_miss", 1'b0, 1'b0, 32'h0);
    upd(32'h600, 32'h900, 1'b1);
    look(32'h600);
    expect_pred("t6_alloc", 1'b1, 1'b1, 32'h900);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
